mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mem_write_monitor.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_write_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// ---------------------------------------------------------------------------
// mem_write_monitor
//
// Purpose:
//   Observes scalar and vector store traffic and turns it into a stream of
//   trace entries. Each accepted event is latched into a one-event slot. The
//   slot is then expanded into individual entries: the scalar store first,
//   then vector lanes 0..NLANES-1. Entries are pushed one per cycle into a
//   DEPTH-entry show-ahead FIFO. Events that arrive while a slot is still
//   expanding are dropped and counted. Each pushed address can be compared
//   against a watch address that raises a sticky halt request.
//
// Ports:
//   clk             single clock, all state updates on the rising edge
//   reset           synchronous, active-low (0 = reset)
//   mem_write       scalar store strobe
//   data_adr        scalar store address
//   write_data      scalar store data
//   mem_write_vec   vector store strobe
//   data_adr_vec    per-lane store addresses (NLANES x WIDTH)
//   write_data_vec  per-lane store data      (NLANES x WIDTH)
//   watch_en        enables the address watch
//   watch_addr      address compared against every pushed entry
//   out_ready       trace consumer ready; pops the head when out_valid=1
//   out_valid       a trace entry is present at the FIFO head
//   out_adr         head entry address  (0 when out_valid=0)
//   out_data        head entry data     (0 when out_valid=0)
//   out_is_vec      head entry came from a vector lane
//   out_lane        head entry lane index (0 for scalar entries)
//   wr_count        entries pushed, saturating
//   drop_count      events dropped, saturating
//   overflow        sticky: at least one event was dropped
//   watch_hit       sticky: a pushed entry matched watch_addr
//   halt_req        sticky: halt request raised by the watch match
// ---------------------------------------------------------------------------
module mem_write_monitor #(
    parameter int WIDTH  = 32,
    parameter int NLANES = 4,
    parameter int DEPTH  = 16,
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_write,
    input  logic [WIDTH-1:0]             data_adr,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         mem_write_vec,
    input  logic [NLANES-1:0][WIDTH-1:0] data_adr_vec,
    input  logic [NLANES-1:0][WIDTH-1:0] write_data_vec,
    input  logic                         watch_en,
    input  logic [WIDTH-1:0]             watch_addr,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_adr,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_is_vec,
    output logic [LANE_W-1:0]            out_lane,
    output logic [31:0]                  wr_count,
    output logic [15:0]                  drop_count,
    output logic                         overflow,
    output logic                         watch_hit,
    output logic                         halt_req
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]  adr;
        logic [WIDTH-1:0]  data;
        logic              is_vec;
        logic [LANE_W-1:0] lane;
    } entry_t;

    // FSM
    state_t state_q;
    state_t state_d;

    // Event slot: one captured event waiting to be expanded.
    logic                         slot_scalar_q;  // scalar entry still to push
    logic                         slot_vec_q;     // vector lanes still to push
    logic [WIDTH-1:0]             slot_adr_q;
    logic [WIDTH-1:0]             slot_data_q;
    logic [NLANES-1:0][WIDTH-1:0] slot_adr_vec_q;
    logic [NLANES-1:0][WIDTH-1:0] slot_data_vec_q;
    logic [LANE_W-1:0]            lane_q;         // next vector lane to push

    // Trace FIFO
    entry_t            fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    entry_t            head;

    // Per-cycle control
    logic   strobe;
    logic   capture;
    logic   push;
    logic   pop;
    logic   can_push;
    logic   drop;
    logic   last_entry;
    entry_t cur_entry;

    assign strobe    = mem_write | mem_write_vec;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign can_push  = (count_q != FULL) | pop;

    // -----------------------------------------------------------------------
    // Entry selection: the scalar store goes first, then lanes in order.
    // -----------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_entry  = '0;
        last_entry = 1'b0;
        if (slot_scalar_q) begin
            cur_entry.adr    = slot_adr_q;
            cur_entry.data   = slot_data_q;
            cur_entry.is_vec = 1'b0;
            cur_entry.lane   = '0;
            last_entry       = !slot_vec_q;
        end else begin
            cur_entry.adr    = slot_adr_vec_q[lane_q];
            cur_entry.data   = slot_data_vec_q[lane_q];
            cur_entry.is_vec = 1'b1;
            cur_entry.lane   = lane_q;
            last_entry       = (lane_q == LAST_LANE);
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and per-cycle controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        push    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    capture = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                // The slot is busy, so any new event is lost, even on the
                // edge that pushes the final entry.
                drop = strobe;
                if (can_push) begin
                    push = 1'b1;
                    if (last_entry) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Event slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_scalar_q   <= 1'b0;
            slot_vec_q      <= 1'b0;
            slot_adr_q      <= '0;
            slot_data_q     <= '0;
            slot_adr_vec_q  <= '0;
            slot_data_vec_q <= '0;
            lane_q          <= '0;
        end else if (capture) begin
            slot_scalar_q   <= mem_write;
            slot_vec_q      <= mem_write_vec;
            slot_adr_q      <= data_adr;
            slot_data_q     <= write_data;
            slot_adr_vec_q  <= data_adr_vec;
            slot_data_vec_q <= write_data_vec;
            lane_q          <= '0;
        end else if (push) begin
            if (last_entry) begin
                slot_scalar_q <= 1'b0;
                slot_vec_q    <= 1'b0;
                lane_q        <= '0;
            end else if (slot_scalar_q) begin
                // Scalar done; lane 0 comes next.
                slot_scalar_q <= 1'b0;
            end else begin
                lane_q <= lane_q + LANE_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Trace FIFO
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. Only the pointers and the count
    // reset; stale contents are never visible because outputs are gated by
    // out_valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr_q] <= cur_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head       = fifo_mem[rd_ptr_q];
    assign out_adr    = out_valid ? head.adr    : '0;
    assign out_data   = out_valid ? head.data   : '0;
    assign out_is_vec = out_valid ? head.is_vec : 1'b0;
    assign out_lane   = out_valid ? head.lane   : '0;

    // -----------------------------------------------------------------------
    // Statistics and sticky status
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            watch_hit  <= 1'b0;
            halt_req   <= 1'b0;
        end else begin
            if (push && (wr_count != '1)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (push && watch_en && (cur_entry.adr == watch_addr)) begin
                watch_hit <= 1'b1;
                halt_req  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// ---------------------------------------------------------------------------
// tb_mem_write_monitor
//
// Directed bench for mem_write_monitor (WIDTH=32, NLANES=4, DEPTH=8).
// A queue-based reference model expands each accepted event into its
// entries and tracks the trace FIFO contents and counters. It is checked
// against the DUT on every falling edge. Hand-computed literal expectations
// in the stimulus pin the model for each directed scenario.
// ---------------------------------------------------------------------------
module tb_mem_write_monitor;

    localparam int WIDTH  = 32;
    localparam int NLANES = 4;
    localparam int DEPTH  = 8;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         mem_write;
    logic [WIDTH-1:0]             data_adr;
    logic [WIDTH-1:0]             write_data;
    logic                         mem_write_vec;
    logic [NLANES-1:0][WIDTH-1:0] data_adr_vec;
    logic [NLANES-1:0][WIDTH-1:0] write_data_vec;
    logic                         watch_en;
    logic [WIDTH-1:0]             watch_addr;
    logic                         out_ready;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_adr;
    logic [WIDTH-1:0]             out_data;
    logic                         out_is_vec;
    logic [1:0]                   out_lane;
    logic [31:0]                  wr_count;
    logic [15:0]                  drop_count;
    logic                         overflow;
    logic                         watch_hit;
    logic                         halt_req;

    mem_write_monitor #(
        .WIDTH (WIDTH),
        .NLANES(NLANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_write     (mem_write),
        .data_adr      (data_adr),
        .write_data    (write_data),
        .mem_write_vec (mem_write_vec),
        .data_adr_vec  (data_adr_vec),
        .write_data_vec(write_data_vec),
        .watch_en      (watch_en),
        .watch_addr    (watch_addr),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_adr       (out_adr),
        .out_data      (out_data),
        .out_is_vec    (out_is_vec),
        .out_lane      (out_lane),
        .wr_count      (wr_count),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .watch_hit     (watch_hit),
        .halt_req      (halt_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: queues of entries, no notion of FSM encoding.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic        is_vec;
        logic [1:0]  lane;
    } ent_t;

    ent_t        fifo_q[$];   // entries in the trace FIFO, head at [0]
    ent_t        slot_q[$];   // entries of the current event not yet pushed
    int unsigned m_wr    = 0;
    int unsigned m_drop  = 0;
    bit          m_ovf   = 1'b0;
    bit          m_watch = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!reset) begin
            fifo_q.delete();
            slot_q.delete();
            m_wr    <= 0;
            m_drop  <= 0;
            m_ovf   <= 1'b0;
            m_watch <= 1'b0;
        end else begin
            // Pop first: a full FIFO then has room for this edge's push.
            if (fifo_q.size() != 0 && out_ready) begin
                void'(fifo_q.pop_front());
            end
            if (slot_q.size() == 0) begin
                if (mem_write) begin
                    slot_q.push_back('{adr: data_adr, data: write_data, is_vec: 1'b0, lane: 2'd0});
                end
                if (mem_write_vec) begin
                    for (int k = 0; k < NLANES; k++) begin
                        slot_q.push_back('{adr: data_adr_vec[k], data: write_data_vec[k],
                                           is_vec: 1'b1, lane: 2'(k)});
                    end
                end
            end else begin
                if (mem_write || mem_write_vec) begin
                    m_drop <= (m_drop == 32'hFFFF) ? m_drop : m_drop + 1;
                    m_ovf  <= 1'b1;
                end
                if (fifo_q.size() < DEPTH) begin
                    if (watch_en && slot_q[0].adr == watch_addr) begin
                        m_watch <= 1'b1;
                    end
                    m_wr <= m_wr + 1;
                    fifo_q.push_back(slot_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_valid", out_valid, fifo_q.size() != 0);
            if (fifo_q.size() != 0) begin
                check("m_adr",    out_adr,    fifo_q[0].adr);
                check("m_data",   out_data,   fifo_q[0].data);
                check("m_is_vec", out_is_vec, fifo_q[0].is_vec);
                check("m_lane",   out_lane,   fifo_q[0].lane);
            end
            check("m_wr_count",   wr_count,   m_wr);
            check("m_drop_count", drop_count, m_drop);
            check("m_overflow",   overflow,   m_ovf);
            check("m_watch_hit",  watch_hit,  m_watch);
            check("m_halt_req",   halt_req,   m_watch);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change only right after a falling edge)
    // -----------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_vec(input logic [31:0] adr_base, input logic [31:0] data_base);
        for (int k = 0; k < NLANES; k++) begin
            data_adr_vec[k]   = adr_base + 32'(4 * k);
            write_data_vec[k] = data_base + 32'(k);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid,  1'b0);
        check({tag, "_adr"},   out_adr,    32'h0);
        check({tag, "_data"},  out_data,   32'h0);
        check({tag, "_isvec"}, out_is_vec, 1'b0);
        check({tag, "_lane"},  out_lane,   2'd0);
        check({tag, "_wr"},    wr_count,   32'd0);
        check({tag, "_drop"},  drop_count, 16'd0);
        check({tag, "_ovf"},   overflow,   1'b0);
        check({tag, "_watch"}, watch_hit,  1'b0);
        check({tag, "_halt"},  halt_req,   1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        mem_write     = 1'b0;
        mem_write_vec = 1'b0;
        watch_en      = 1'b0;
        out_ready     = 1'b0;
        cyc(2);
        reset = 1'b1;
    endtask

    logic [31:0] exp_adr   [5] = '{32'h50, 32'h200, 32'h204, 32'h208, 32'h20C};
    logic        exp_isvec [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  exp_lane  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        // Reset with a strobe held high: it must be ignored.
        reset         = 1'b0;
        mem_write     = 1'b1;
        mem_write_vec = 1'b1;
        data_adr      = 32'hDEAD;
        write_data    = 32'hBEEF;
        set_vec(32'hF00, 32'h0);
        watch_en      = 1'b0;
        watch_addr    = 32'h0;
        out_ready     = 1'b0;
        cyc(3);
        check_zero_outputs("rst");
        reset         = 1'b1;
        mem_write     = 1'b0;
        mem_write_vec = 1'b0;
        cyc(3);
        check("rst_strobe_ignored_wr", wr_count, 32'd0);
        check("rst_strobe_ignored_valid", out_valid, 1'b0);

        // Scalar store, consumer ready.
        do_reset();
        mem_write  = 1'b1;
        data_adr   = 32'h100;
        write_data = 32'hAA;
        out_ready  = 1'b1;
        cyc(1);
        mem_write = 1'b0;
        check("scalar_not_yet_valid", out_valid, 1'b0);
        cyc(1);
        check("scalar_valid", out_valid, 1'b1);
        check("scalar_adr", out_adr, 32'h100);
        check("scalar_data", out_data, 32'hAA);
        check("scalar_isvec", out_is_vec, 1'b0);
        check("scalar_lane", out_lane, 2'd0);
        check("scalar_wr", wr_count, 32'd1);
        cyc(1);
        check("scalar_popped", out_valid, 1'b0);

        // Scalar plus vector in the same cycle: five entries in order.
        do_reset();
        mem_write     = 1'b1;
        data_adr      = 32'h50;
        write_data    = 32'h55;
        mem_write_vec = 1'b1;
        set_vec(32'h200, 32'h1000);
        cyc(1);
        mem_write     = 1'b0;
        mem_write_vec = 1'b0;
        cyc(5);
        check("both_wr", wr_count, 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("both_order_adr", out_adr, exp_adr[i]);
            check("both_order_isvec", out_is_vec, exp_isvec[i]);
            check("both_order_lane", out_lane, exp_lane[i]);
            cyc(1);
        end
        check("both_drained", out_valid, 1'b0);

        // Fill to DEPTH, stall with a held slot, drop during stall, drain.
        do_reset();
        mem_write_vec = 1'b1;
        set_vec(32'h300, 32'h3000);
        cyc(1);
        mem_write_vec = 1'b0;
        cyc(5);
        mem_write_vec = 1'b1;
        set_vec(32'h400, 32'h4000);
        cyc(1);
        mem_write_vec = 1'b0;
        cyc(5);
        mem_write_vec = 1'b1;
        set_vec(32'h500, 32'h5000);
        cyc(2);
        mem_write_vec = 1'b0;
        check("stall_wr", wr_count, 32'd8);
        check("stall_drop", drop_count, 16'd1);
        check("stall_ovf", overflow, 1'b1);
        check("stall_head", out_adr, 32'h300);
        cyc(3);
        check("stall_hold_wr", wr_count, 32'd8);
        out_ready = 1'b1;
        cyc(16);
        check("drain_wr", wr_count, 32'd12);
        check("drain_empty", out_valid, 1'b0);
        check("drain_drop", drop_count, 16'd1);

        // Strobe while expanding is dropped; strobe after return is taken.
        do_reset();
        out_ready  = 1'b1;
        mem_write  = 1'b1;
        data_adr   = 32'h600;
        write_data = 32'h6;
        cyc(1);
        data_adr   = 32'h700;
        write_data = 32'h7;
        cyc(1);
        data_adr   = 32'h800;
        write_data = 32'h8;
        cyc(1);
        mem_write = 1'b0;
        check("busy_drop", drop_count, 16'd1);
        check("busy_wr1", wr_count, 32'd1);
        cyc(1);
        check("busy_wr2", wr_count, 32'd2);
        check("busy_accept_adr", out_adr, 32'h800);

        // Address watch on lane 2.
        do_reset();
        watch_en      = 1'b1;
        watch_addr    = 32'h208;
        out_ready     = 1'b1;
        mem_write_vec = 1'b1;
        set_vec(32'h200, 32'h2000);
        cyc(1);
        mem_write_vec = 1'b0;
        cyc(2);
        check("watch_before", watch_hit, 1'b0);
        cyc(1);
        check("watch_hit", watch_hit, 1'b1);
        check("watch_halt", halt_req, 1'b1);
        cyc(5);
        check("watch_sticky", halt_req, 1'b1);

        // Reset in the middle of a vector expansion.
        do_reset();
        mem_write_vec = 1'b1;
        set_vec(32'h900, 32'h9000);
        cyc(1);
        mem_write_vec = 1'b0;
        cyc(1);
        check("midrst_pre_wr", wr_count, 32'd1);
        reset = 1'b0;
        cyc(1);
        check_zero_outputs("midrst");
        reset = 1'b1;
        cyc(8);
        check("midrst_no_stale_valid", out_valid, 1'b0);
        check("midrst_no_stale_wr", wr_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
